// File: rtl/write_if.sv
// Write-side FIFO bus: upstream stream, synced read pointer, and memory/pointer outputs.
// slave = write controller, master = whoever drives the stream and read pointer.
interface write_if #(
  parameter int WIDTH         = 1,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     rx_tvalid;
  logic [WIDTH-1:0]         rx_tdata;
  logic                     rx_tready;
  logic [ADDRESS_WIDTH-1:0] read_pointer_synced;
  logic                     write_enable;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [WIDTH-1:0]         write_data;
  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [ADDRESS_WIDTH-1:0] write_level;

  modport slave (
    input  rx_tvalid, rx_tdata, read_pointer_synced,
    output rx_tready, write_enable, write_address, write_data,
           write_pointer, write_level
  );

  modport master (
    output rx_tvalid, rx_tdata, read_pointer_synced,
    input  rx_tready, write_enable, write_address, write_data,
           write_pointer, write_level
  );
endinterface

// File: rtl/write.sv
// Async FIFO write-domain controller: registered memory strobes, published binary
// write pointer, conservative full/ready and fill level against the synced read pointer.
module write #(
  parameter int WIDTH         = 1,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic  write_aclk,
  input  logic  write_areset_n,
  write_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;

  logic          accept;
  logic [AW-1:0] wp_q, wp_d;
  logic          rdy_q, rdy_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] lvl_q, lvl_d;

  // ready is a register, so accept never sees rx_tvalid feed back into ready
  always_comb begin
    accept = bus.rx_tvalid & rdy_q;
    wp_d   = wp_q + AW'(accept);
    rdy_d  = (wp_d + AW'(1)) != bus.read_pointer_synced;
    lvl_d  = wp_d - bus.read_pointer_synced;
    data_d = accept ? bus.rx_tdata : data_q;
  end

  // ptr_q samples the pre-edge wp, so it moves only once the covered word has
  // already been presented to the memory on the previous edge
  always_ff @(posedge write_aclk or negedge write_areset_n) begin
    if (!write_areset_n) begin
      wp_q   <= '0;
      rdy_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      lvl_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rdy_q  <= rdy_d;
      we_q   <= accept;
      addr_q <= wp_q;
      data_q <= data_d;
      ptr_q  <= wp_q;
      lvl_q  <= lvl_d;
    end
  end

  assign bus.rx_tready     = rdy_q;
  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
  assign bus.write_pointer = ptr_q;
  assign bus.write_level   = lvl_q;
endmodule
